// File: rtl/key_mode_multi_if.sv
// Key/mode bundle: raw active-low keys in, debounced levels, event pulses and
// per-channel mode fields out.
interface key_mode_multi_if #(
  parameter int NCH = 4,
  parameter int MW  = 1
);
  logic [NCH-1:0]    key_in;
  logic [NCH-1:0]    key_level;
  logic [NCH-1:0]    press_pulse;
  logic [NCH-1:0]    release_pulse;
  logic [NCH-1:0]    long_pulse;
  logic [NCH*MW-1:0] mode;

  modport master (
    output key_in,
    input  key_level, press_pulse, release_pulse, long_pulse, mode
  );

  modport slave (
    input  key_in,
    output key_level, press_pulse, release_pulse, long_pulse, mode
  );
endinterface

// File: rtl/key_mode_multi.sv
// Multi-channel key debouncer with hysteresis, press/release/long-press pulses
// and a per-channel wrapping mode counter that a long press reloads.
module key_mode_multi #(
  parameter int NCH       = 4,
  parameter int CNT_MAX   = 5_000_000,
  parameter int LO_TH     = CNT_MAX * 9 / 10,
  parameter int LONG_CNT  = 50_000_000,
  parameter int NMODE     = 2,
  parameter int MODE_INIT = 1
) (
  input logic            clk,
  input logic            rstn,
  key_mode_multi_if.slave bus
);

  localparam int MW = (NMODE > 2) ? $clog2(NMODE) : 1;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int HW = $clog2(LONG_CNT + 1);

  localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_LO    = CW'(LO_TH);
  localparam logic [HW-1:0] HOLD_TOP  = HW'(LONG_CNT);
  localparam logic [MW-1:0] MODE_LAST = MW'(NMODE - 1);
  localparam logic [MW-1:0] MODE_RST  = MW'(MODE_INIT);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic          sync1_reg;
      logic          sync2_reg;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          level_reg;
      logic          level_next;
      logic          level_d_reg;
      logic [HW-1:0] hold_reg;
      logic [HW-1:0] hold_next;
      logic          long_reg;
      logic          long_hit;
      logic [MW-1:0] mode_reg;
      logic [MW-1:0] mode_next;
      logic          press;

      // Saturating integrator: counts up while the synced key is low, down while high.
      always_comb begin
        cnt_next = cnt_reg;
        if (!sync2_reg) begin
          if (cnt_reg != CNT_TOP) cnt_next = cnt_reg + 1'b1;
        end else begin
          if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
        end
      end

      always_comb begin
        level_next = level_reg;
        if (cnt_reg == CNT_TOP)     level_next = 1'b1;
        else if (cnt_reg <= CNT_LO) level_next = 1'b0;
      end

      always_comb begin
        hold_next = '0;
        if (level_reg) begin
          hold_next = (hold_reg != HOLD_TOP) ? hold_reg + 1'b1 : hold_reg;
        end
      end

      // Fires only on the step into saturation, so once per press.
      assign long_hit = (hold_next == HOLD_TOP) && (hold_reg != HOLD_TOP);
      assign press    = level_reg & ~level_d_reg;

      always_comb begin
        mode_next = mode_reg;
        if (long_hit) begin
          mode_next = MODE_RST;
        end else if (press) begin
          mode_next = (mode_reg == MODE_LAST) ? '0 : mode_reg + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
          hold_reg    <= '0;
          long_reg    <= 1'b0;
          mode_reg    <= MODE_RST;
        end else begin
          sync1_reg   <= bus.key_in[gi];
          sync2_reg   <= sync1_reg;
          cnt_reg     <= cnt_next;
          level_reg   <= level_next;
          level_d_reg <= level_reg;
          hold_reg    <= hold_next;
          long_reg    <= long_hit;
          mode_reg    <= mode_next;
        end
      end

      assign bus.key_level[gi]          = level_reg;
      assign bus.press_pulse[gi]        = press;
      assign bus.release_pulse[gi]      = ~level_reg & level_d_reg;
      assign bus.long_pulse[gi]         = long_reg;
      assign bus.mode[gi*MW +: MW]      = mode_reg;
    end
  endgenerate

endmodule

// File: tb/tb_key_mode_multi.sv
// Directed bench for key_mode_multi: pulse events are predicted into a queue at
// stimulus time and matched by a monitor as the design emits them.
module tb_key_mode_multi;
  localparam int NCH       = 4;
  localparam int CNT_MAX   = 8;
  localparam int LO_TH     = 6;
  localparam int LONG_CNT  = 20;
  localparam int NMODE     = 3;
  localparam int MODE_INIT = 1;
  localparam int MW        = 2;
  localparam int P_LAT     = CNT_MAX + 3;
  localparam int R_LAT     = CNT_MAX - LO_TH + 3;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   total;
  int   bad;
  int   exp_mode [NCH];
  ev_t  exp_q [$];

  key_mode_multi_if #(.NCH(NCH), .MW(MW)) bus ();

  key_mode_multi #(
    .NCH(NCH), .CNT_MAX(CNT_MAX), .LO_TH(LO_TH), .LONG_CNT(LONG_CNT),
    .NMODE(NMODE), .MODE_INIT(MODE_INIT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void chk(string tag, int obs, int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at cyc=%0d", tag, obs, expv, cyc);
    end
  endfunction

  task automatic push_ev(int kind, int ch, int at);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int mode_of(int ch);
    return int'(bus.mode[ch*MW +: MW]);
  endfunction

  function automatic void model_press(int ch);
    exp_mode[ch] = (exp_mode[ch] == NMODE - 1) ? 0 : exp_mode[ch] + 1;
  endfunction

  // Monitor: every pulse seen must match the oldest predicted event.
  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      for (int k = 0; k < 3; k++) begin
        logic p;
        ev_t  e;
        p = (k == K_PRESS) ? bus.press_pulse[ch] :
            (k == K_REL)   ? bus.release_pulse[ch] : bus.long_pulse[ch];
        if (p) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("spurious_pulse_ch%0d_k%0d", ch, k), exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_ch", ch, e.ch);
            chk("ev_cyc", cyc, e.cyc);
            $display("event kind=%0d ch=%0d cyc=%0d expected_cyc=%0d", k, ch, cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < NCH; i++) exp_mode[i] = MODE_INIT;
    rstn       = 1'b0;
    bus.key_in = '1;
    step(3);
    chk("rst_level", int'(bus.key_level), 0);
    chk("rst_press", int'(bus.press_pulse), 0);
    chk("rst_release", int'(bus.release_pulse), 0);
    chk("rst_long", int'(bus.long_pulse), 0);
    chk("rst_mode", int'(bus.mode), 'h55);
    rstn = 1'b1;
    step(2);

    // Channel 0: press latency and first mode step.
    bus.key_in[0] = 1'b0;
    push_ev(K_PRESS, 0, cyc + P_LAT);
    model_press(0);
    step(P_LAT - 1);
    chk("a_level_before", int'(bus.key_level[0]), 0);
    step(1);
    chk("a_level", int'(bus.key_level[0]), 1);
    step(1);
    chk("a_mode", mode_of(0), exp_mode[0]);
    chk("a_press_done", int'(bus.press_pulse[0]), 0);

    // Channel 0: release latency, mode holds.
    bus.key_in[0] = 1'b1;
    push_ev(K_REL, 0, cyc + R_LAT);
    step(R_LAT - 1);
    chk("b_level_hold", int'(bus.key_level[0]), 1);
    step(1);
    chk("b_level", int'(bus.key_level[0]), 0);
    chk("b_mode", mode_of(0), exp_mode[0]);
    step(12);

    // Channel 1: three presses walk the mode through the wrap.
    for (int k = 0; k < 3; k++) begin
      bus.key_in[1] = 1'b0;
      push_ev(K_PRESS, 1, cyc + P_LAT);
      model_press(1);
      step(P_LAT + 1);
      chk($sformatf("c_mode_%0d", k), mode_of(1), exp_mode[1]);
      bus.key_in[1] = 1'b1;
      push_ev(K_REL, 1, cyc + R_LAT);
      step(R_LAT + 12);
    end
    chk("c_mode_final", mode_of(1), MODE_INIT);

    // Channel 2: short glitches are absorbed; a clean press still takes the full ramp.
    for (int k = 0; k < 4; k++) begin
      bus.key_in[2] = 1'b0;
      step(5);
      bus.key_in[2] = 1'b1;
      step(10);
      chk($sformatf("d_level_%0d", k), int'(bus.key_level[2]), 0);
    end
    chk("d_mode", mode_of(2), exp_mode[2]);
    bus.key_in[2] = 1'b0;
    push_ev(K_PRESS, 2, cyc + P_LAT);
    model_press(2);
    step(P_LAT);
    chk("d_press_level", int'(bus.key_level[2]), 1);
    step(1);
    bus.key_in[2] = 1'b1;
    push_ev(K_REL, 2, cyc + R_LAT);
    step(R_LAT + 12);

    // Channel 3: long press fires once and restores the initial mode.
    bus.key_in[3] = 1'b0;
    push_ev(K_PRESS, 3, cyc + P_LAT);
    push_ev(K_LONG, 3, cyc + P_LAT + LONG_CNT);
    model_press(3);
    step(P_LAT + 1);
    chk("e_mode_pressed", mode_of(3), exp_mode[3]);
    step(29);
    exp_mode[3] = MODE_INIT;
    chk("e_mode_after_long", mode_of(3), exp_mode[3]);
    chk("e_queue_drained", exp_q.size(), 0);
    bus.key_in[3] = 1'b1;
    push_ev(K_REL, 3, cyc + R_LAT);
    step(R_LAT + 12);

    // All channels together, then reset mid-hold and re-press.
    bus.key_in = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      push_ev(K_PRESS, ch, cyc + P_LAT);
      model_press(ch);
    end
    step(P_LAT);
    chk("f_level_all", int'(bus.key_level), 'hF);
    step(1);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("f_mode_ch%0d", ch), mode_of(ch), exp_mode[ch]);
    step(4);
    rstn = 1'b0;
    #1;
    for (int ch = 0; ch < NCH; ch++) exp_mode[ch] = MODE_INIT;
    chk("f_rst_level", int'(bus.key_level), 0);
    chk("f_rst_mode", int'(bus.mode), 'h55);
    step(3);
    chk("f_rst_release", int'(bus.release_pulse), 0);
    rstn = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      push_ev(K_PRESS, ch, cyc + P_LAT);
      model_press(ch);
    end
    step(P_LAT - 1);
    chk("f_repress_early", int'(bus.key_level), 0);
    step(1);
    chk("f_repress_level", int'(bus.key_level), 'hF);
    step(1);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("f_remode_ch%0d", ch), mode_of(ch), exp_mode[ch]);
    bus.key_in = '1;
    for (int ch = 0; ch < NCH; ch++) push_ev(K_REL, ch, cyc + R_LAT);
    step(R_LAT + 12);
    chk("end_level", int'(bus.key_level), 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_mode_multi.md
KEY_MODE_MULTI -- requirements
Module: key_mode_multi

Interface
REQ-001 SHALL provide parameter NCH, default 4, meaning number of independent key channels (1..16).
REQ-002 SHALL provide parameter CNT_MAX, default 5_000_000, meaning the debounce integrator ceiling in clock cycles.
REQ-003 SHALL provide parameter LO_TH, default CNT_MAX*9/10, meaning the release threshold; LO_TH < CNT_MAX is required.
REQ-004 SHALL provide parameter LONG_CNT, default 50_000_000, meaning the long-press duration in cycles of debounced press.
REQ-005 SHALL provide parameter NMODE, default 2, meaning the number of mode values per channel (>=2); MW = clog2(NMODE), minimum 1.
REQ-006 SHALL provide parameter MODE_INIT, default 1, meaning the per-channel mode value after reset and after a long press (< NMODE).
REQ-007 SHALL provide port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-008 SHALL provide port rstn, input, 1, the reset: asynchronous assert, active-low.
REQ-009 SHALL provide port key_in, input, NCH, raw asynchronous keys, 0 = pressed.
REQ-010 SHALL provide port key_level, output, NCH, debounced state, 1 = pressed.
REQ-011 SHALL provide port press_pulse, output, NCH, one-cycle pulse on each debounced press.
REQ-012 SHALL provide port release_pulse, output, NCH, one-cycle pulse on each debounced release.
REQ-013 SHALL provide port long_pulse, output, NCH, one-cycle pulse when a press reaches LONG_CNT.
REQ-014 SHALL provide port mode, output, NCH*MW, channel i mode in bits [i*MW +: MW].

Function
REQ-015 SHALL pass each key_in bit through a 2-flop synchronizer; both flops reset to 1 (released).
REQ-016 SHALL keep a per-channel integrator cnt of width clog2(CNT_MAX+1); synced key 0: cnt <= min(cnt+1, CNT_MAX); synced key 1: cnt <= max(cnt-1, 0); it never wraps in either direction.
REQ-017 SHALL register key_level <= 1 on the edge where cnt == CNT_MAX, <= 0 on the edge where cnt <= LO_TH, and hold otherwise (hysteresis band LO_TH+1..CNT_MAX-1).
REQ-018 SHALL drive press_pulse = key_level & ~key_level_d and release_pulse = ~key_level & key_level_d from registers; each is high exactly one cycle per transition.
REQ-019 SHALL make the debounced press latency CNT_MAX+3 rising edges from the first edge sampling key_in low, and the release latency CNT_MAX-LO_TH+3 edges from a fully integrated state.
REQ-020 SHALL advance mode on the edge where press_pulse is high: NMODE-1 wraps to 0, otherwise +1; the new value is visible the following cycle.
REQ-021 SHALL keep a per-channel hold counter; it clears to 0 while key_level = 0, increments each cycle key_level = 1, and saturates at LONG_CNT.
REQ-022 SHALL assert long_pulse for the single cycle in which hold first equals LONG_CNT, at most once per press, and SHALL load mode <= MODE_INIT on that same edge.
REQ-023 SHALL suppress any low burst shorter than the integrator ramp; no pulse or mode change results.
REQ-024 SHALL make channels fully independent; simultaneous events on different channels each produce their own pulses in the same cycle.
REQ-025 SHALL perform all state changes only on clk; no derived clocks or edge-triggering on internal signals.

Reset
REQ-026 SHALL, while rstn = 0, force cnt = 0, hold = 0, key_level = 0, key_level_d = 0, every mode field = MODE_INIT, sync flops = 1, and all pulses = 0.
REQ-027 SHALL, when rstn asserts mid-press, abort it with no release_pulse, and SHALL, after deassertion with a key held, require a full CNT_MAX+3 edge ramp before the press registers.

Verification (CNT_MAX=8, LO_TH=6, LONG_CNT=20, NMODE=3, MODE_INIT=1, NCH=4)
REQ-028 SHALL cover this case: key_in[0] held low from edge 1 -> key_level[0] and press_pulse[0] rise after edge 11; press_pulse lasts 1 cycle; mode[0] is 2 after edge 12.
REQ-029 SHALL cover this case: the key released after full integration -> key_level[0] falls after edge 5 of the release, release_pulse[0] lasts 1 cycle, and mode is unchanged.
REQ-030 SHALL cover this case: 3 press/release cycles on channel 1 -> mode[1] goes 1->2->0->1 (wrap verified).
REQ-031 SHALL cover this case: 5-cycle low glitches separated by 10-cycle highs on channel 2 -> no pulses, key_level[2] stays 0, and cnt never underflows.
REQ-032 SHALL cover this case: channel 3 held for 30 cycles after press -> exactly one long_pulse[3], 20 cycles after press_pulse, and mode[3] = 1 afterwards.
REQ-033 SHALL cover this case: all 4 keys pressed together, then rstn pulsed low mid-hold -> simultaneous press_pulses, then all outputs reset, no release_pulse, and re-press after CNT_MAX+3 edges.
